// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the two-master GPIO arbiter: FSM state encoding
// and master index constants.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    // Index of the granted master from a one-hot grant vector.
    function automatic logic owner_of(input logic [1:0] gnt);
        return gnt[M1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester always wins, a tie goes
// to the master favoured by ptr (0 = M0, 1 = M1). Purely combinational.
module rr_arb2
    import gpio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[M0] && req[M1]) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/gpio_arbiter.sv
// Arbitrates two masters onto a single GPIO register port: one transaction
// per three cycles (IDLE -> ISSUE -> RESP), round-robin between masters.
module gpio_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_a,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_done,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_a,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_done,
    output logic [DW-1:0] m1_rd,
    output logic [1:0]    gpio_a,
    output logic          gpio_we,
    output logic [DW-1:0] gpio_wd,
    input  logic [DW-1:0] gpio_rd
);

    state_e        state_q;
    logic          ptr_q;
    logic          owner_q;
    logic          we_q;
    logic [1:0]    a_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rd_q;
    logic          gpio_we_q;
    logic          m0_done_q;
    logic          m1_done_q;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          owner_d;
    logic          we_d;
    logic [1:0]    a_d;
    logic [DW-1:0] wd_d;

    assign req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Request fields of whichever master the arbiter would grant this cycle.
    always_comb begin
        owner_d = owner_of(gnt);
        we_d    = owner_d ? m1_we : m0_we;
        a_d     = owner_d ? m1_a  : m0_a;
        wd_d    = owner_d ? m1_wd : m0_wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            wd_q      <= '0;
            rd_q      <= '0;
            gpio_we_q <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    if (|gnt) begin
                        owner_q   <= owner_d;
                        we_q      <= we_d;
                        a_q       <= a_d;
                        wd_q      <= wd_d;
                        gpio_we_q <= we_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_q      <= gpio_rd;
                    gpio_we_q <= 1'b0;
                    m0_done_q <= ~owner_q;
                    m1_done_q <= owner_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    ptr_q     <= ~owner_q;
                    state_q   <= IDLE;
                end
                default: begin
                    gpio_we_q <= 1'b0;
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // gpio_we_q mirrors we_q only while in ISSUE; a/wd simply hold.
    assign gpio_a  = a_q;
    assign gpio_wd = wd_q;
    assign gpio_we = gpio_we_q;
    assign m0_done = m0_done_q;
    assign m1_done = m1_done_q;
    assign m0_rd   = rd_q;
    assign m1_rd   = rd_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed, self-checking bench for gpio_arbiter.
module tb_gpio_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [1:0]    m0_a, m1_a;
    logic [DW-1:0] m0_wd, m1_wd;
    logic          m0_done, m1_done;
    logic [DW-1:0] m0_rd, m1_rd;
    logic [1:0]    gpio_a;
    logic          gpio_we;
    logic [DW-1:0] gpio_wd;
    logic [DW-1:0] gpio_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_arbiter #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_we   (m0_we),
        .m0_a    (m0_a),
        .m0_wd   (m0_wd),
        .m0_done (m0_done),
        .m0_rd   (m0_rd),
        .m1_req  (m1_req),
        .m1_we   (m1_we),
        .m1_a    (m1_a),
        .m1_wd   (m1_wd),
        .m1_done (m1_done),
        .m1_rd   (m1_rd),
        .gpio_a  (gpio_a),
        .gpio_we (gpio_we),
        .gpio_wd (gpio_wd),
        .gpio_rd (gpio_rd)
    );

    // Advance one cycle; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'b11; m0_wd = 32'hFFFF_FFFF;
        m1_req = 1'b1; m1_we = 1'b1; m1_a = 2'b11; m1_wd = 32'hFFFF_FFFF;
        gpio_rd = 32'hCAFE_F00D;
        step(); step(); step();
        checks++; if (gpio_we !== 1'b0) begin failures++; $display("FAIL rst_gpio_we got=%0h exp=0", gpio_we); end
        checks++; if (gpio_a !== 2'b00) begin failures++; $display("FAIL rst_gpio_a got=%0h exp=0", gpio_a); end
        checks++; if (gpio_wd !== 32'h0) begin failures++; $display("FAIL rst_gpio_wd got=%h exp=0", gpio_wd); end
        checks++; if (m0_done !== 1'b0 || m1_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b%b exp=00", m1_done, m0_done); end
        checks++; if (m0_rd !== 32'h0 || m1_rd !== 32'h0) begin failures++; $display("FAIL rst_rd got=%h/%h exp=0", m0_rd, m1_rd); end
        m0_req = 1'b0; m0_we = 1'b0; m0_a = 2'b00; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_a = 2'b00; m1_wd = '0;
        gpio_rd = '0;
        rst = 1'b1;
        step();
        checks++; if (gpio_we !== 1'b0 || m0_done !== 1'b0 || m1_done !== 1'b0) begin failures++; $display("FAIL rst_idle got=we%b d%b%b exp=0", gpio_we, m1_done, m0_done); end
    endtask

    task automatic test_single_write();
        m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'b10; m0_wd = 32'hDEAD_BEEF;
        step();
        checks++; if (gpio_we !== 1'b1) begin failures++; $display("FAIL wr_gpio_we got=%0h exp=1", gpio_we); end
        checks++; if (gpio_a !== 2'b10) begin failures++; $display("FAIL wr_gpio_a got=%0h exp=2", gpio_a); end
        checks++; if (gpio_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_gpio_wd got=%h exp=deadbeef", gpio_wd); end
        checks++; if (m0_done !== 1'b0) begin failures++; $display("FAIL wr_early_done got=%0h exp=0", m0_done); end
        step();
        checks++; if (m0_done !== 1'b1) begin failures++; $display("FAIL wr_m0_done got=%0h exp=1", m0_done); end
        checks++; if (m1_done !== 1'b0) begin failures++; $display("FAIL wr_m1_done got=%0h exp=0", m1_done); end
        checks++; if (gpio_we !== 1'b0) begin failures++; $display("FAIL wr_resp_we got=%0h exp=0", gpio_we); end
        m0_req = 1'b0; m0_we = 1'b0; m0_wd = '0;
        step();
        checks++; if (m0_done !== 1'b0) begin failures++; $display("FAIL wr_done_one_cycle got=%0h exp=0", m0_done); end
        checks++; if (gpio_a !== 2'b10 || gpio_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hold got=%0h/%h exp=2/deadbeef", gpio_a, gpio_wd); end
    endtask

    // M0 holds req across its done; pointer favours M1 but the lone M0 still wins.
    task automatic test_back_to_back();
        m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'b01; m0_wd = 32'h0000_0011;
        step(); step();
        checks++; if (m0_done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%0h exp=1", m0_done); end
        step();
        m0_wd = 32'h0000_0022;
        checks++; if (gpio_we !== 1'b0) begin failures++; $display("FAIL b2b_idle_we got=%0h exp=0", gpio_we); end
        step();
        checks++; if (gpio_we !== 1'b1 || gpio_wd !== 32'h0000_0022) begin failures++; $display("FAIL b2b_second_issue got=we%0h wd%h exp=we1 wd22", gpio_we, gpio_wd); end
        step();
        checks++; if (m0_done !== 1'b1 || m1_done !== 1'b0) begin failures++; $display("FAIL b2b_second_done got=%b%b exp=01", m1_done, m0_done); end
        m0_req = 1'b0; m0_we = 1'b0;
        step(); step();
        checks++; if (m0_done !== 1'b0 || gpio_we !== 1'b0) begin failures++; $display("FAIL b2b_quiet got=d%0h we%0h exp=0", m0_done, gpio_we); end
    endtask

    task automatic test_single_read();
        m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'b00; m1_wd = 32'h5555_5555;
        gpio_rd = 32'h0000_00A5;
        step();
        checks++; if (gpio_we !== 1'b0) begin failures++; $display("FAIL rd_issue_we got=%0h exp=0", gpio_we); end
        checks++; if (gpio_a !== 2'b00) begin failures++; $display("FAIL rd_gpio_a got=%0h exp=0", gpio_a); end
        step();
        checks++; if (m1_done !== 1'b1 || m0_done !== 1'b0) begin failures++; $display("FAIL rd_done got=%b%b exp=10", m1_done, m0_done); end
        checks++; if (m1_rd !== 32'h0000_00A5) begin failures++; $display("FAIL rd_m1_rd got=%h exp=000000a5", m1_rd); end
        gpio_rd = 32'h0000_00FF;
        #1;
        checks++; if (m1_rd !== 32'h0000_00A5 || m0_rd !== 32'h0000_00A5) begin failures++; $display("FAIL rd_captured got=%h/%h exp=000000a5", m0_rd, m1_rd); end
        checks++; if (gpio_we !== 1'b0) begin failures++; $display("FAIL rd_resp_we got=%0h exp=0", gpio_we); end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_req_withdrawn();
        m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'b01;
        gpio_rd = 32'h1357_9BDF;
        step();
        m1_req = 1'b0; m1_a = 2'b11;
        gpio_rd = 32'h0000_0000;
        #1;
        checks++; if (gpio_a !== 2'b01) begin failures++; $display("FAIL wd_latched_a got=%0h exp=1", gpio_a); end
        step();
        checks++; if (m1_done !== 1'b1) begin failures++; $display("FAIL wd_done got=%0h exp=1", m1_done); end
        checks++; if (m1_rd !== 32'h0000_0000) begin failures++; $display("FAIL wd_rd got=%h exp=0", m1_rd); end
        step(); step(); step();
        checks++; if (m1_done !== 1'b0 || m0_done !== 1'b0 || gpio_we !== 1'b0) begin failures++; $display("FAIL wd_no_regrant got=d%b%b we%0h exp=0", m1_done, m0_done, gpio_we); end
        checks++; if (gpio_a !== 2'b01) begin failures++; $display("FAIL wd_idle_a got=%0h exp=1", gpio_a); end
    endtask

    task automatic test_contention();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'b01; m0_wd = 32'hAAAA_0000;
        m1_req = 1'b1; m1_we = 1'b1; m1_a = 2'b11; m1_wd = 32'hBBBB_0000;
        step();
        checks++; if (gpio_a !== 2'b01 || gpio_wd !== 32'hAAAA_0000) begin failures++; $display("FAIL ct_first_issue got=%0h/%h exp=1/aaaa0000", gpio_a, gpio_wd); end
        step();
        checks++; if (m0_done !== 1'b1 || m1_done !== 1'b0) begin failures++; $display("FAIL ct_n2 got=%b%b exp=01", m1_done, m0_done); end
        m0_req = 1'b0;
        step();
        checks++; if (m0_done !== 1'b0 || m1_done !== 1'b0) begin failures++; $display("FAIL ct_n3 got=%b%b exp=00", m1_done, m0_done); end
        step();
        checks++; if (gpio_a !== 2'b11 || gpio_we !== 1'b1) begin failures++; $display("FAIL ct_second_issue got=a%0h we%0h exp=a3 we1", gpio_a, gpio_we); end
        step();
        checks++; if (m1_done !== 1'b1 || m0_done !== 1'b0) begin failures++; $display("FAIL ct_n5 got=%b%b exp=10", m1_done, m0_done); end
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        int unsigned eo;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_a = 2'b01;
        m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'b10;
        for (int t = 0; t < 6; t++) begin
            eo = t % 2;
            step();
            checks++; if (gpio_a !== ((eo == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fair_issue%0d got=%0h exp_owner=M%0d", t, gpio_a, eo); end
            step();
            checks++; if (m0_done !== (eo == 0) || m1_done !== (eo == 1)) begin failures++; $display("FAIL fair_done%0d got=%b%b exp_owner=M%0d", t, m1_done, m0_done, eo); end
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
    endtask

    task automatic test_midflight_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_a = 2'b11; m0_wd = 32'h1234_5678;
        step();
        checks++; if (gpio_we !== 1'b1 || gpio_a !== 2'b11) begin failures++; $display("FAIL mr_issue got=we%0h a%0h exp=we1 a3", gpio_we, gpio_a); end
        rst = 1'b0;
        #1;
        checks++; if (gpio_we !== 1'b0 || gpio_a !== 2'b00 || gpio_wd !== 32'h0) begin failures++; $display("FAIL mr_async got=we%0h a%0h wd%h exp=0", gpio_we, gpio_a, gpio_wd); end
        m0_req = 1'b0; m0_we = 1'b0;
        step();
        checks++; if (m0_done !== 1'b0 || m1_done !== 1'b0) begin failures++; $display("FAIL mr_no_done got=%b%b exp=00", m1_done, m0_done); end
        rst = 1'b1;
        step(); step();
        checks++; if (m0_done !== 1'b0 || gpio_we !== 1'b0 || gpio_a !== 2'b00 || gpio_wd !== 32'h0 || m0_rd !== 32'h0) begin failures++; $display("FAIL mr_after got=d%0h we%0h a%0h wd%h rd%h exp=0", m0_done, gpio_we, gpio_a, gpio_wd, m0_rd); end
        m1_req = 1'b1; m1_we = 1'b0; m1_a = 2'b10;
        gpio_rd = 32'h0000_0077;
        step(); step();
        checks++; if (m1_done !== 1'b1 || m1_rd !== 32'h0000_0077) begin failures++; $display("FAIL mr_idle_resume got=d%0h rd%h exp=d1 rd77", m1_done, m1_rd); end
        m1_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_single_read();
        test_req_withdrawn();
        test_contention();
        test_fairness();
        test_midflight_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of write data, read data and the GPIO port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 m0_req, m1_req  input  1 each  master request; held high until matching done.
REQ-005 m0_we, m1_we  input  1 each  1=write, 0=read.
REQ-006 m0_a, m1_a  input  2 each  GPIO word address (bits [3:2]).
REQ-007 m0_wd, m1_wd  input  DW each  write data.
REQ-008 m0_done, m1_done  output  1 each  one-cycle completion pulse.
REQ-009 m0_rd, m1_rd  output  DW each  read data, valid when the matching done is high.
REQ-010 gpio_a  output  2  address to GPIO block.
REQ-011 gpio_we  output  1  write enable to GPIO block.
REQ-012 gpio_wd  output  DW  write data to GPIO block.
REQ-013 gpio_rd  input  DW  combinational read data from GPIO block.

Function
REQ-014 The FSM shall have the states IDLE, ISSUE and RESP.
REQ-015 IDLE: if any req is high, the arbiter shall pick an owner, latch the owner's we/a/wd and go to ISSUE; otherwise it shall stay in IDLE.
REQ-016 Arbitration shall be round-robin with a 1-bit priority pointer (reset 0 = M0 favoured); a lone requester shall always win.
REQ-017 After every RESP the pointer shall be set to the non-owner, so a master that is continuously requesting is served within two transactions.
REQ-018 ISSUE lasts exactly one cycle: gpio_a/gpio_wd shall carry the latched values and gpio_we shall equal the latched we; at that cycle's edge gpio_rd shall be captured into the read register; next state is RESP.
REQ-019 RESP lasts exactly one cycle: done of the owner only shall be 1, and that owner's rd shall present the captured value; next state is IDLE.
REQ-020 Latency: req sampled high in cycle N gives the GPIO access in cycle N+1 and done in cycle N+2; maximum throughput is one transaction per 3 cycles.
REQ-021 gpio_we shall be 0 in every state except ISSUE.
REQ-022 gpio_a/gpio_wd shall hold the last latched values outside ISSUE.
REQ-023 Both m0_rd and m1_rd shall be driven from the single read register.
REQ-024 A write transaction shall still pulse done; its rd value is don't-care.
REQ-025 Simultaneous req in IDLE: the pointer shall decide; the loser stays pending with no done.
REQ-026 A req dropped after capture shall not abort the transaction: ISSUE and RESP complete and done still pulses.
REQ-027 Requester inputs shall be ignored in ISSUE and RESP; the latched copy is authoritative.
REQ-028 A req still high in the cycle after its done shall be treated as a new request.

Reset
REQ-029 While rst=0 the FSM shall be in IDLE, pointer=0, latched a/we/wd=0, read register=0, gpio_we=0, both done=0, gpio_a=0, gpio_wd=0, m0_rd/m1_rd=0.
REQ-030 Reset asserted mid-transaction shall abandon it immediately, with no done pulse and no GPIO write afterwards.
REQ-031 The first arbitration after reset release shall occur on the first rising edge with rst=1.

Structure
REQ-032 The state encoding (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10) and the master index constants (M0=0, M1=1) shall live in the shared package gpio_arb_pkg.
REQ-033 The round-robin decision shall be a sub-module rr_arb2: inputs req[1:0] and ptr; outputs one-hot gnt[1:0]; purely combinational.
REQ-034 The FSM, latches and read register shall be in gpio_arbiter; there shall be no other sub-modules.

Verification
REQ-035 Single write: M0 req, we=1, a=2'b10, wd=32'hDEADBEEF -> gpio_we=1, gpio_a=2'b10, gpio_wd=32'hDEADBEEF in cycle N+1; m0_done=1 in N+2; m1_done stays 0.
REQ-036 Single read: M1 req, we=0, a=2'b00, gpio_rd=32'h0000_00A5 during ISSUE -> m1_done=1 with m1_rd=32'h0000_00A5 in N+2; gpio_we=0 throughout.
REQ-037 Contention: both req from reset with pointer=0 -> M0 is served first (done at N+2), M1 next (done at N+5); done pulses never overlap.
REQ-038 Fairness: both req held for 6 transactions -> grant order strictly M0, M1, M0, M1, M0, M1.
REQ-039 Mid-flight reset: rst=0 during ISSUE of M0 write a=2'b11 -> no done; after release all outputs are 0 and the state is IDLE.
REQ-040 Req withdrawn: M1 drops req in ISSUE -> m1_done still pulses in the next cycle, then the FSM goes to IDLE with no further grant.
